// File: rtl/lmsm_sequencer_if.sv
// Pipeline/memory side <-> LM/SM sequencer bundle.
// The master drives the request and memory-ready inputs; the slave (the sequencer) drives the transfer outputs.
interface lmsm_sequencer_if;
  logic        flush;
  logic        start;
  logic        is_store;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic        mem_ready;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [2:0]  req_reg;
  logic        stall;
  logic        busy;
  logic        done;

  modport master (
    output flush, start, is_store, base_addr, reg_mask, mem_ready,
    input  req_valid, req_we, req_addr, req_reg, stall, busy, done
  );

  modport slave (
    input  flush, start, is_store, base_addr, reg_mask, mem_ready,
    output req_valid, req_we, req_addr, req_reg, stall, busy, done
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load/Store-Multiple sequencer: turns one LM/SM into one memory transfer
// per set mask bit, lowest register first, at ascending (wrapping) addresses.
module lmsm_sequencer (
  input  logic             clk,
  input  logic             resetn,
  lmsm_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q;
  logic [7:0]  mask_q;
  logic [15:0] addr_q;
  logic        we_q;
  logic [2:0]  reg_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic [7:0]  mask_d;
  logic [2:0]  reg_d;
  logic [2:0]  start_reg_d;

  // Lowest set bit wins (R0 has highest priority).
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Remaining mask after the current transfer retires, and the register that follows it.
  always_comb begin
    mask_d      = mask_q & (mask_q - 8'd1);
    reg_d       = lowest_bit(mask_d);
    start_reg_d = lowest_bit(bus.reg_mask);
  end

  // Sequencer FSM; every req_*/busy/done output is a register so mem_ready never reaches them combinationally.
  always_ff @(posedge clk) begin
    if (!resetn || bus.flush) begin
      state_q <= IDLE;
      mask_q  <= 8'd0;
      addr_q  <= 16'd0;
      we_q    <= 1'b0;
      reg_q   <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            we_q   <= bus.is_store;
            addr_q <= bus.base_addr;
            mask_q <= bus.reg_mask;
            reg_q  <= start_reg_d;
            if (bus.reg_mask != 8'd0) begin
              state_q <= RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              // Empty mask: nothing to move, just report completion.
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.mem_ready) begin
            mask_q <= mask_d;
            addr_q <= addr_q + 16'd1;
            reg_q  <= reg_d;
            if (mask_d == 8'd0) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          // start is deliberately not looked at here.
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stall must hold the issuing instruction in the same cycle start arrives, hence the combinational term.
  always_comb begin
    bus.stall = resetn & (busy_q |
                ((state_q == IDLE) & bus.start & (bus.reg_mask != 8'd0) & ~bus.flush));
  end

  assign bus.req_valid = valid_q;
  assign bus.req_we    = we_q;
  assign bus.req_addr  = addr_q;
  assign bus.req_reg   = reg_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: transfer-list reference model plus directed and random stimulus.
module tb_lmsm_sequencer;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  lmsm_sequencer_if bus();
  lmsm_sequencer dut (.clk(clk), .resetn(resetn), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Reference model: pending transfer list built from the mask when a start is accepted.
  typedef struct packed { logic [2:0] r; logic [15:0] a; } xfer_t;
  xfer_t       pend[$];
  int          phase;      // 0 idle, 1 transferring, 2 completion cycle
  logic        m_we;
  logic [15:0] m_a;
  bit          model_ok = 1'b0;
  int          cyc = 0, start_cyc = 0, done_at = -1, done_cnt = 0, valid_cnt = 0;
  logic [19:0] hlog[$];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  function automatic logic [19:0] ent(input logic we, input logic [2:0] r, input logic [15:0] a);
    return {we, r, a};
  endfunction

  task automatic chk_log(input string n, input int idx, input logic [19:0] e);
    chk(n, (idx < hlog.size()) ? {12'd0, hlog[idx]} : 32'hDEAD_BEEF, {12'd0, e});
  endtask

  // Model advance on each rising edge using the inputs seen at that edge.
  always @(posedge clk) begin
    cyc++;
    if (!resetn) model_ok = 1'b1;
    if (!resetn || bus.flush) begin
      phase = 0;
      pend.delete();
    end else begin
      case (phase)
        0: if (bus.start) begin
          m_we = bus.is_store;
          m_a  = bus.base_addr;
          for (int i = 0; i < 8; i++) begin
            if (bus.reg_mask[i]) begin
              pend.push_back({3'(i), m_a});
              m_a = m_a + 16'd1;
            end
          end
          phase = (pend.size() != 0) ? 1 : 2;
        end
        1: if (bus.mem_ready) begin
          void'(pend.pop_front());
          if (pend.size() == 0) phase = 2;
        end
        default: phase = 0;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  logic e_stall;
  always @(negedge clk) begin
    #1;
    if (model_ok) begin
      e_stall = resetn && ((phase == 1) ||
                (phase == 0 && bus.start && bus.reg_mask != 8'd0 && !bus.flush));
      chk("req_valid", bus.req_valid, phase == 1);
      chk("busy", bus.busy, phase == 1);
      chk("done", bus.done, phase == 2);
      chk("stall", bus.stall, e_stall);
      if (phase == 1 && pend.size() != 0) begin
        chk("req_reg", bus.req_reg, pend[0].r);
        chk("req_addr", bus.req_addr, pend[0].a);
        chk("req_we", bus.req_we, m_we);
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = cyc - start_cyc;
      end
      if (bus.req_valid === 1'b1) valid_cnt++;
      if (bus.req_valid === 1'b1 && bus.mem_ready && resetn)
        hlog.push_back({bus.req_we, bus.req_reg, bus.req_addr});
    end
  end

  task automatic drive(input bit st, input bit we, input logic [15:0] b, input logic [7:0] m,
                       input bit rdy, input bit fl = 1'b0, input bit rn = 1'b1);
    @(negedge clk);
    resetn        = rn;
    bus.start     = st;
    bus.is_store  = we;
    bus.base_addr = b;
    bus.reg_mask  = m;
    bus.mem_ready = rdy;
    bus.flush     = fl;
  endtask

  task automatic idle(input int n, input bit rdy = 1'b1);
    repeat (n) drive(1'b0, 1'b0, 16'h0, 8'h0, rdy);
  endtask

  task automatic clr();
    hlog.delete();
    done_cnt  = 0;
    done_at   = -1;
    valid_cnt = 0;
  endtask

  int d1;

  initial begin
    resetn = 1'b0;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.base_addr = '0;
    bus.reg_mask = '0; bus.mem_ready = 1'b0; bus.flush = 1'b0;

    // Reset held with start asserted.
    drive(1'b1, 1'b0, 16'h1111, 8'hFF, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h1111, 8'hFF, 1'b1, 1'b0, 1'b0);
    #2;
    chk("rst_valid", bus.req_valid, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    idle(1);
    #2;
    chk("rst_no_xfer", hlog.size(), 0);

    // LM, memory always ready.
    clr();
    drive(1'b1, 1'b0, 16'h0100, 8'hA5, 1'b1); start_cyc = cyc;
    idle(6); #2;
    chk("lm_cnt", hlog.size(), 4);
    chk_log("lm_x0", 0, ent(1'b0, 3'd0, 16'h0100));
    chk_log("lm_x1", 1, ent(1'b0, 3'd2, 16'h0101));
    chk_log("lm_x2", 2, ent(1'b0, 3'd5, 16'h0102));
    chk_log("lm_x3", 3, ent(1'b0, 3'd7, 16'h0103));
    chk("lm_done_at", done_at, 5);
    chk("lm_done_cnt", done_cnt, 1);
    chk("lm_valid_cyc", valid_cnt, 4);

    // SM with two wait cycles on the first transfer.
    clr();
    drive(1'b1, 1'b1, 16'h2000, 8'h03, 1'b1); start_cyc = cyc;
    idle(2, 1'b0);
    idle(4, 1'b1); #2;
    chk_log("sm_x0", 0, ent(1'b1, 3'd0, 16'h2000));
    chk_log("sm_x1", 1, ent(1'b1, 3'd1, 16'h2001));
    chk("sm_cnt", hlog.size(), 2);
    chk("sm_valid_cyc", valid_cnt, 4);
    chk("sm_done_at", done_at, 5);

    // Empty mask, then address wrap.
    clr();
    drive(1'b1, 1'b0, 16'h1234, 8'h00, 1'b1); start_cyc = cyc;
    idle(3); #2;
    chk("empty_done_at", done_at, 1);
    chk("empty_valid_cyc", valid_cnt, 0);
    clr();
    drive(1'b1, 1'b0, 16'hFFFF, 8'hC0, 1'b1); start_cyc = cyc;
    idle(4); #2;
    chk_log("wrap_x0", 0, ent(1'b0, 3'd6, 16'hFFFF));
    chk_log("wrap_x1", 1, ent(1'b0, 3'd7, 16'h0000));
    chk("wrap_done_at", done_at, 3);

    // Flush during the third request, then a fresh start.
    clr();
    drive(1'b1, 1'b0, 16'h3000, 8'hFF, 1'b1); start_cyc = cyc;
    idle(2);
    drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    idle(1); #2;
    chk("fl_busy", bus.busy, 0);
    chk("fl_stall", bus.stall, 0);
    chk("fl_no_done", done_cnt, 0);
    drive(1'b1, 1'b0, 16'h3100, 8'h01, 1'b1); start_cyc = cyc;
    idle(3); #2;
    chk("fl_cnt", hlog.size(), 4);
    chk_log("fl_x2", 2, ent(1'b0, 3'd2, 16'h3002));
    chk_log("fl_x3", 3, ent(1'b0, 3'd0, 16'h3100));
    chk("fl_done_cnt", done_cnt, 1);
    chk("fl_done_at", done_at, 2);

    // Starts during RUN and DONE are ignored.
    clr();
    drive(1'b1, 1'b0, 16'h4000, 8'h0F, 1'b1); start_cyc = cyc;
    idle(1);
    drive(1'b1, 1'b1, 16'h5000, 8'hF0, 1'b1);
    idle(2);
    drive(1'b1, 1'b1, 16'h5000, 8'hF0, 1'b1);
    idle(1); #2;
    d1 = done_at;
    chk("busy_done_at", d1, 5);
    drive(1'b1, 1'b0, 16'h6000, 8'h10, 1'b1); start_cyc = cyc;
    idle(3); #2;
    chk("busy_cnt", hlog.size(), 5);
    chk_log("busy_x3", 3, ent(1'b0, 3'd3, 16'h4003));
    chk_log("busy_x4", 4, ent(1'b0, 3'd4, 16'h6000));
    chk("busy_done_cnt", done_cnt, 2);

    // Random traffic checked cycle by cycle against the model.
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 2) == 0,
            1'($urandom),
            16'($urandom),
            ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 49) != 0);
    end
    idle(12);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
